// File: rtl/axi_lite_regfile_if.sv
// AXI-lite bus bundle for the register file: write address, write data,
// write response, read address and read data channels.
interface axi_lite_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   write_addr;
  logic                write_addr_valid;
  logic                write_addr_ready;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W/8-1:0] write_strb;
  logic                write_data_valid;
  logic                write_data_ready;
  logic [1:0]          write_resp;
  logic                write_resp_valid;
  logic                write_resp_ready;
  logic [ADDR_W-1:0]   read_addr;
  logic                read_addr_valid;
  logic                read_addr_ready;
  logic [DATA_W-1:0]   read_data;
  logic [1:0]          read_resp;
  logic                read_data_valid;
  logic                read_data_ready;

  modport slave (
    input  write_addr, write_addr_valid, write_data, write_strb, write_data_valid,
    input  write_resp_ready, read_addr, read_addr_valid, read_data_ready,
    output write_addr_ready, write_data_ready, write_resp, write_resp_valid,
    output read_addr_ready, read_data, read_resp, read_data_valid
  );

  modport master (
    output write_addr, write_addr_valid, write_data, write_strb, write_data_valid,
    output write_resp_ready, read_addr, read_addr_valid, read_data_ready,
    input  write_addr_ready, write_data_ready, write_resp, write_resp_valid,
    input  read_addr_ready, read_data, read_resp, read_data_valid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI-lite slave register file with byte strobes and SLVERR responses.
// Define AXI_REGFILE_WCOUNT_EN to turn the last register into a read-only OKAY-write counter.
module axi_lite_regfile #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic clk,
  input logic rstn,
  axi_lite_regfile_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_have;
  logic              w_have;
  logic [ADDR_W-1:0] cmt_addr;
  logic [DATA_W-1:0] cmt_data;
  logic [STRB_W-1:0] cmt_strb;
  logic [IDX_W-1:0]  cmt_idx;
  logic              cmt_ok;
  logic              ar_hs;
  logic              r_hs;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = addr >> LSB;
    return word < ADDR_W'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = addr >> LSB;
    return word[IDX_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // A held beat wins over the bus; a beat arriving on the commit edge is used directly.
  always_comb begin
    aw_hs    = bus.write_addr_valid & bus.write_addr_ready;
    w_hs     = bus.write_data_valid & bus.write_data_ready;
    aw_have  = aw_held | aw_hs;
    w_have   = w_held | w_hs;
    cmt_addr = aw_held ? addr_q : bus.write_addr;
    cmt_data = w_held ? data_q : bus.write_data;
    cmt_strb = w_held ? strb_q : bus.write_strb;
    cmt_idx  = word_idx(cmt_addr);
`ifdef AXI_REGFILE_WCOUNT_EN
    cmt_ok   = in_range(cmt_addr) && (cmt_idx != IDX_W'(NUM_REGS - 1));
`else
    cmt_ok   = in_range(cmt_addr);
`endif
    ar_hs    = bus.read_addr_valid & bus.read_addr_ready;
    r_hs     = bus.read_data_valid & bus.read_data_ready;
  end

  always_ff @(posedge clk) begin
    if (aw_hs) addr_q <= bus.write_addr;
    if (w_hs) begin
      data_q <= bus.write_data;
      strb_q <= bus.write_strb;
    end
  end

  // Write channel FSM and register array
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state              <= W_IDLE;
      aw_held              <= 1'b0;
      w_held               <= 1'b0;
      bus.write_addr_ready <= 1'b0;
      bus.write_data_ready <= 1'b0;
      bus.write_resp       <= RESP_OKAY;
      bus.write_resp_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_have && w_have) begin
            if (cmt_ok) begin
              regs[cmt_idx] <= merge_bytes(regs[cmt_idx], cmt_data, cmt_strb);
`ifdef AXI_REGFILE_WCOUNT_EN
              regs[NUM_REGS-1] <= regs[NUM_REGS-1] + DATA_W'(1);
`endif
            end
            bus.write_resp       <= cmt_ok ? RESP_OKAY : RESP_SLVERR;
            bus.write_resp_valid <= 1'b1;
            bus.write_addr_ready <= 1'b0;
            bus.write_data_ready <= 1'b0;
            aw_held              <= 1'b0;
            w_held               <= 1'b0;
            w_state              <= W_RESP;
          end else begin
            aw_held              <= aw_have;
            w_held               <= w_have;
            bus.write_addr_ready <= !aw_have;
            bus.write_data_ready <= !w_have;
          end
        end
        W_RESP: begin
          if (bus.write_resp_ready) begin
            bus.write_resp_valid <= 1'b0;
            bus.write_resp       <= RESP_OKAY;
            bus.write_addr_ready <= 1'b1;
            bus.write_data_ready <= 1'b1;
            w_state              <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; sees pre-commit register contents on a same-edge write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state             <= R_IDLE;
      bus.read_addr_ready <= 1'b0;
      bus.read_data_valid <= 1'b0;
      bus.read_data       <= '0;
      bus.read_resp       <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            if (in_range(bus.read_addr)) begin
              bus.read_data <= regs[word_idx(bus.read_addr)];
              bus.read_resp <= RESP_OKAY;
            end else begin
              bus.read_data <= '0;
              bus.read_resp <= RESP_SLVERR;
            end
            bus.read_data_valid <= 1'b1;
            bus.read_addr_ready <= 1'b0;
            r_state             <= R_DATA;
          end else begin
            bus.read_addr_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            bus.read_data_valid <= 1'b0;
            bus.read_addr_ready <= 1'b1;
            r_state             <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: a word-array model predicts every response,
// a negedge monitor compares the DUT against it, and literal reads pin the model.
module tb_axi_lite_regfile;

  logic clk;
  logic rstn;

  axi_lite_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_regfile #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mreg [16];
  logic [1:0]  exp_wresp;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp;
  bit          wresp_pending = 1'b0;
  bit          rdata_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    logic [31:0] w;
    w = addr >> 2;
    resp = 2'b00;
    if (w >= 32'd16) resp = 2'b10;
`ifdef AXI_REGFILE_WCOUNT_EN
    if (w == 32'd15) resp = 2'b10;
`endif
    if (resp == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mreg[w[3:0]][8*b +: 8] = data[8*b +: 8];
`ifdef AXI_REGFILE_WCOUNT_EN
      mreg[15] = mreg[15] + 32'd1;
`endif
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    logic [31:0] w;
    w = addr >> 2;
    if (w >= 32'd16) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = mreg[w[3:0]];
      resp = 2'b00;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      check("wresp_valid", 64'(bus.write_resp_valid), 64'(wresp_pending));
      if (wresp_pending) begin
        check("wresp_code", 64'(bus.write_resp), 64'(exp_wresp));
        check("w_readys_low_in_resp", 64'({bus.write_addr_ready, bus.write_data_ready}), 64'd0);
      end
      check("rdata_valid", 64'(bus.read_data_valid), 64'(rdata_pending));
      if (rdata_pending) begin
        check("rdata_value", 64'(bus.read_data), 64'(exp_rdata));
        check("rresp_code", 64'(bus.read_resp), 64'(exp_rresp));
        check("ar_ready_low_in_data", 64'(bus.read_addr_ready), 64'd0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_aw_ready"}, 64'(bus.write_addr_ready), 64'd0);
    check({tag, "_w_ready"},  64'(bus.write_data_ready), 64'd0);
    check({tag, "_b_valid"},  64'(bus.write_resp_valid), 64'd0);
    check({tag, "_b_resp"},   64'(bus.write_resp), 64'd0);
    check({tag, "_ar_ready"}, 64'(bus.read_addr_ready), 64'd0);
    check({tag, "_r_valid"},  64'(bus.read_data_valid), 64'd0);
    check({tag, "_r_data"},   64'(bus.read_data), 64'd0);
    check({tag, "_r_resp"},   64'(bus.read_resp), 64'd0);
  endtask

  // lead > 0: data beat leads the address by lead cycles; lead < 0: address leads.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int hold,
                           input bit abort);
    int c;
    bit a_on, d_on, a_done, d_done, ah, dh, hs;
    logic [1:0] r;
    model_write(addr, data, strb, r);
    bus.write_addr = addr;
    bus.write_data = data;
    bus.write_strb = strb;
    a_on = (lead <= 0);
    d_on = (lead >= 0);
    a_done = 1'b0;
    d_done = 1'b0;
    c = 0;
    bus.write_addr_valid = a_on;
    bus.write_data_valid = d_on;
    while (!(a_done && d_done) && c < 20) begin
      @(negedge clk);
      ah = bus.write_addr_valid && bus.write_addr_ready;
      dh = bus.write_data_valid && bus.write_data_ready;
      if (d_done && !a_done) check("w_ready_dropped", 64'(bus.write_data_ready), 64'd0);
      if (a_done && !d_done) check("aw_ready_dropped", 64'(bus.write_addr_ready), 64'd0);
      @(posedge clk); #1;
      c++;
      if (ah) begin a_done = 1'b1; bus.write_addr_valid = 1'b0; end
      if (dh) begin d_done = 1'b1; bus.write_data_valid = 1'b0; end
      if (!a_on && c >= lead)  begin a_on = 1'b1; bus.write_addr_valid = 1'b1; end
      if (!d_on && c >= -lead) begin d_on = 1'b1; bus.write_data_valid = 1'b1; end
    end
    bus.write_addr_valid = 1'b0;
    bus.write_data_valid = 1'b0;
    check("w_capture_in_time", 64'(a_done && d_done), 64'd1);
    if (!(a_done && d_done)) return;
    check("wresp_latency", 64'(bus.write_resp_valid), 64'd1);
    exp_wresp = r;
    wresp_pending = 1'b1;
    if (abort) return;
    repeat (hold) begin @(posedge clk); #1; end
    bus.write_resp_ready = 1'b1;
    c = 0;
    hs = 1'b0;
    while (!hs && c < 10) begin
      @(negedge clk);
      hs = bus.write_resp_valid && bus.write_resp_ready;
      @(posedge clk); #1;
      c++;
    end
    bus.write_resp_ready = 1'b0;
    wresp_pending = 1'b0;
    check("wresp_handshake", 64'(hs), 64'd1);
    check("w_readys_back", 64'({bus.write_addr_ready, bus.write_data_ready}), 64'd3);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int hold, output logic [31:0] got);
    int c;
    bit ah, hs;
    got = 32'hFFFF_FFFF;
    model_read(addr, exp_rdata, exp_rresp);
    bus.read_addr = addr;
    bus.read_addr_valid = 1'b1;
    c = 0;
    ah = 1'b0;
    while (!ah && c < 20) begin
      @(negedge clk);
      ah = bus.read_addr_valid && bus.read_addr_ready;
      @(posedge clk); #1;
      c++;
    end
    bus.read_addr_valid = 1'b0;
    check("ar_capture_in_time", 64'(ah), 64'd1);
    if (!ah) return;
    check("rdata_latency", 64'(bus.read_data_valid), 64'd1);
    rdata_pending = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.read_data_ready = 1'b1;
    c = 0;
    hs = 1'b0;
    while (!hs && c < 10) begin
      @(negedge clk);
      hs = bus.read_data_valid && bus.read_data_ready;
      if (hs) got = bus.read_data;
      @(posedge clk); #1;
      c++;
    end
    bus.read_data_ready = 1'b0;
    rdata_pending = 1'b0;
    check("rdata_handshake", 64'(hs), 64'd1);
    check("ar_ready_back", 64'(bus.read_addr_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] got;
    bus.write_addr = '0; bus.write_addr_valid = 1'b0;
    bus.write_data = '0; bus.write_strb = '0; bus.write_data_valid = 1'b0;
    bus.write_resp_ready = 1'b0;
    bus.read_addr = '0; bus.read_addr_valid = 1'b0; bus.read_data_ready = 1'b0;
    model_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("in_reset");
    @(negedge clk);
    rstn = 1'b1;
    #1 check("ready_before_first_edge", 64'({bus.write_addr_ready, bus.read_addr_ready}), 64'd0);
    @(posedge clk); #1;
    check("ready_after_first_edge",
          64'({bus.write_addr_ready, bus.write_data_ready, bus.read_addr_ready}), 64'd7);

    // Same-cycle address and data
    write_txn(32'h3C, 32'd100, 4'hF, 0, 0, 1'b0);
    read_txn(32'h3C, 0, got);
`ifdef AXI_REGFILE_WCOUNT_EN
    check("lit_counter_idle", 64'(got), 64'd0);
`else
    check("lit_reg_0x3c", 64'(got), 64'd100);
`endif

    // Data two cycles ahead of address
    write_txn(32'h08, 32'hDEADBEEF, 4'hF, 2, 0, 1'b0);
    read_txn(32'h08, 0, got);
    check("lit_reg_0x08", 64'(got), 64'hDEADBEEF);

    // Byte strobes
    write_txn(32'h04, 32'h11223344, 4'hF, 0, 0, 1'b0);
    write_txn(32'h04, 32'hAABBCCDD, 4'b0101, -1, 0, 1'b0);
    read_txn(32'h04, 0, got);
    check("lit_strb_merge", 64'(got), 64'h11BB33DD);

    // Out of range
    write_txn(32'h40, 32'h12345678, 4'hF, 0, 0, 1'b0);
    read_txn(32'h44, 0, got);
    check("lit_oor_read_zero", 64'(got), 64'd0);
    read_txn(32'h08, 0, got);
    check("lit_oor_no_change", 64'(got), 64'hDEADBEEF);

    // Zero strobe: OKAY, no change
    write_txn(32'h0A, 32'h0BAD0BAD, 4'h0, 1, 0, 1'b0);
    read_txn(32'h08, 0, got);
    check("lit_zero_strb", 64'(got), 64'hDEADBEEF);

    // Back-pressure on both response channels
    write_txn(32'h0C, 32'h00005A5A, 4'h3, -3, 5, 1'b0);
    read_txn(32'h0C, 5, got);
    check("lit_reg_0x0c", 64'(got), 64'h5A5A);

    // Reset while the write response is pending
    write_txn(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);
    #2 wresp_pending = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1 check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    read_txn(32'h10, 0, got);
    check("lit_reset_clears", 64'(got), 64'd0);
    read_txn(32'h3C, 0, got);
    check("lit_0x3c_after_reset", 64'(got), 64'd0);

    write_txn(32'h00, 32'h1, 4'hF, 0, 0, 1'b0);
    write_txn(32'h04, 32'h2, 4'hF, 1, 0, 1'b0);
    write_txn(32'h08, 32'h3, 4'hF, -1, 0, 1'b0);
    read_txn(32'h3C, 0, got);
`ifdef AXI_REGFILE_WCOUNT_EN
    check("lit_counter_three", 64'(got), 64'd3);
`else
    check("lit_0x3c_untouched", 64'(got), 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
